// File: rtl/hdmi_timing_ctrl.sv
// Video timing sequencer: generates sync, data-enable, pixel coordinates and
// line/frame markers. A frame always runs to completion before going idle.
module hdmi_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic             PClk,
    input  logic             Reset,
    input  logic             Enable,
    output logic             Hsync,
    output logic             Vsync,
    output logic             Video_En,
    output logic [CNT_W-1:0] Pixel_X,
    output logic [CNT_W-1:0] Pixel_Y,
    output logic             Line_Start,
    output logic             Frame_Start,
    output logic             Busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_en_q, video_en_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;

    logic             h_last;
    logic             frame_last;
    logic             active_d;

    // Outputs are decoded from the next-state values so that every registered
    // output lines up with the registered (h, v) it describes.
    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        h_last        = (h_q == H_LAST);
        frame_last    = h_last && (v_q == V_LAST);

        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (Enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (frame_last) begin
                    // Frame boundary: either start the next frame or go quiet.
                    h_d     = '0;
                    v_d     = '0;
                    state_d = Enable ? ST_RUN : ST_IDLE;
                end else begin
                    h_d     = h_last ? '0 : h_q + CNT_W'(1);
                    v_d     = h_last ? v_q + CNT_W'(1) : v_q;
                    state_d = Enable ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase

        active_d      = (state_d != ST_IDLE);
        busy_d        = (state_d == ST_RUN);
        video_en_d    = active_d && (h_d < H_ACT) && (v_d < V_ACT);
        hsync_d       = (active_d && (h_d >= HS_START) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (active_d && (v_d >= VS_START) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
        line_start_d  = busy_d && (h_d == '0);
        frame_start_d = line_start_d && (v_d == '0);
    end

    always_ff @(posedge PClk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_en_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_en_q    <= video_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign Video_En    = video_en_q;
    assign Pixel_X     = h_q;
    assign Pixel_Y     = v_q;
    assign Line_Start  = line_start_q;
    assign Frame_Start = frame_start_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench: a default-timing instance for the horizontal schedule and a
// small-timing, positive-polarity instance for whole-frame and enable sequencing.
module tb_hdmi_timing_ctrl;

    localparam int BHA = 16, BHF = 4, BHS = 6, BHB = 4;
    localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;
    localparam int BHT = BHA + BHF + BHS + BHB;   // 30
    localparam int BVT = BVA + BVF + BVS + BVB;   // 19
    localparam int BFR = BHT * BVT;               // 570

    logic       clk = 1'b0;
    logic       rst_a, en_a, rst_b, en_b;
    logic       a_hs, a_vs, a_de, a_ls, a_fs, a_busy;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_de, b_ls, b_fs, b_busy;
    logic [9:0] b_x, b_y;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    hdmi_timing_ctrl u_dut_a (
        .PClk(clk), .Reset(rst_a), .Enable(en_a),
        .Hsync(a_hs), .Vsync(a_vs), .Video_En(a_de),
        .Pixel_X(a_x), .Pixel_Y(a_y),
        .Line_Start(a_ls), .Frame_Start(a_fs), .Busy(a_busy)
    );

    hdmi_timing_ctrl #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .SYNC_POL(1'b1), .CNT_W(10)
    ) u_dut_b (
        .PClk(clk), .Reset(rst_b), .Enable(en_b),
        .Hsync(b_hs), .Vsync(b_vs), .Video_En(b_de),
        .Pixel_X(b_x), .Pixel_Y(b_y),
        .Line_Start(b_ls), .Frame_Start(b_fs), .Busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected small-instance outputs at frame position p (cycles since frame start).
    task automatic check_b(input int p, input bit run);
        int  h, v;
        bit  hs_on, vs_on;
        h     = p % BHT;
        v     = (p / BHT) % BVT;
        hs_on = (h >= BHA + BHF) && (h < BHA + BHF + BHS);
        vs_on = (v >= BVA + BVF) && (v < BVA + BVF + BVS);
        chk("b_x", b_x, h);
        chk("b_y", b_y, v);
        chk("b_de", b_de, (h < BHA) && (v < BVA));
        chk("b_hs", b_hs, hs_on);
        chk("b_vs", b_vs, vs_on);
        chk("b_ls", b_ls, run && (h == 0));
        chk("b_fs", b_fs, run && (h == 0) && (v == 0));
        chk("b_busy", b_busy, run);
    endtask

    task automatic check_b_idle();
        chk("bi_x", b_x, 0);
        chk("bi_y", b_y, 0);
        chk("bi_de", b_de, 0);
        chk("bi_hs", b_hs, 0);
        chk("bi_vs", b_vs, 0);
        chk("bi_ls", b_ls, 0);
        chk("bi_fs", b_fs, 0);
        chk("bi_busy", b_busy, 0);
    endtask

    initial begin
        int hs_low, first_low, last_ls, last_fs;
        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;

        // ---- Default timing: reset state and line schedule ----
        tick(); tick();
        chk("a_rst_x", a_x, 0);
        chk("a_rst_y", a_y, 0);
        chk("a_rst_de", a_de, 0);
        chk("a_rst_hs", a_hs, 1);
        chk("a_rst_vs", a_vs, 1);
        chk("a_rst_ls", a_ls, 0);
        chk("a_rst_fs", a_fs, 0);
        chk("a_rst_busy", a_busy, 0);

        rst_a = 1'b0; en_a = 1'b1;
        tick();
        chk("a_first_x", a_x, 0);
        chk("a_first_y", a_y, 0);
        chk("a_first_de", a_de, 1);
        chk("a_first_fs", a_fs, 1);
        chk("a_first_ls", a_ls, 1);
        chk("a_first_busy", a_busy, 1);

        hs_low = 0; first_low = -1; last_ls = 0;
        for (int k = 1; k <= 1650; k++) begin
            int h, v;
            tick();
            h = k % 800;
            v = k / 800;
            chk("a_x", a_x, h);
            chk("a_y", a_y, v);
            chk("a_de", a_de, h < 640);
            chk("a_hs", a_hs, !((h >= 656) && (h < 752)));
            chk("a_vs", a_vs, 1);
            chk("a_ls", a_ls, h == 0);
            chk("a_fs", a_fs, 0);
            if (k < 800 && a_hs == 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = k;
            end
            if (a_ls) begin
                chk("a_ls_period", k - last_ls, 800);
                last_ls = k;
            end
        end
        chk("a_hs_len", hs_low, 96);
        chk("a_hs_first", first_low, 656);
        $display("phase default_lines: checks so far=%0d", n_total);
        rst_a = 1'b1; en_a = 1'b0;

        // ---- Small timing: reset, idle hold, two full frames ----
        tick(); tick();
        check_b_idle();
        rst_b = 1'b0;
        tick();
        check_b_idle();
        en_b = 1'b1;
        tick();
        check_b(0, 1'b1);
        last_fs = 0;
        for (int p = 1; p <= 2 * BFR; p++) begin
            tick();
            check_b(p, 1'b1);
            if (b_fs) begin
                chk("b_fs_gap", p - last_fs, BFR);
                last_fs = p;
            end
        end
        chk("b_fs_last", last_fs, 2 * BFR);
        $display("phase frames: checks so far=%0d", n_total);

        // ---- Drop Enable mid-frame: drain to the end, then idle ----
        for (int p = 1; p < BFR; p++) begin
            en_b = (p <= 150);
            tick();
            check_b(p, p <= 150);
        end
        tick();
        check_b_idle();
        for (int i = 0; i < 40; i++) begin
            tick();
            check_b_idle();
        end
        $display("phase drain_idle: checks so far=%0d", n_total);

        // ---- Drop and re-raise Enable within a frame: no restart ----
        en_b = 1'b1;
        tick();
        check_b(0, 1'b1);
        for (int p = 1; p <= BFR; p++) begin
            en_b = !((p > 150) && (p < 300));
            tick();
            check_b(p, en_b);
        end
        chk("b_fs_boundary", b_fs, 1);
        $display("phase drain_resume: checks so far=%0d", n_total);

        // ---- Reset inside hsync and vsync with Enable held high ----
        for (int p = 1; p <= 442; p++) begin
            tick();
            check_b(p, 1'b1);
        end
        chk("b_pre_rst_hs", b_hs, 1);
        chk("b_pre_rst_vs", b_vs, 1);
        rst_b = 1'b1;
        tick();
        check_b_idle();
        rst_b = 1'b0;
        tick();
        check_b(0, 1'b1);
        for (int p = 1; p <= 40; p++) begin
            tick();
            check_b(p, 1'b1);
        end
        $display("phase reset_midframe: checks so far=%0d", n_total);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
